note_scheduler: RTL and testbench

- Sequences note events produced by the keyboard hit decoder (note, octave and length codes) into timed tone commands for the buzzer tone generator.
- Buffers events in a small FIFO and plays each one for a duration set by its length code.
- Inserts a fixed articulation gap between consecutive notes.
- Supports pause and flush, so free-play and record/replay share one tone datapath.

---
 rtl/note_scheduler_pkg.sv | 27 ++
 rtl/note_scheduler_fifo.sv | 51 +++++
 rtl/note_scheduler.sv | 125 ++++++++++++
 tb/tb_note_scheduler.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/note_scheduler_pkg.sv
// Shared widths, FSM encoding and event layout for the note scheduler slice.
package note_scheduler_pkg;
  localparam int NOTE_BITS   = 3;
  localparam int OCTAVE_BITS = 3;
  localparam int LENGTH_BITS = 3;
  localparam int UNIT_BITS   = 7;
  localparam int EVENT_BITS  = NOTE_BITS + OCTAVE_BITS + LENGTH_BITS;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  typedef struct packed {
    logic [NOTE_BITS-1:0]   note;
    logic [OCTAVE_BITS-1:0] octave;
    logic [LENGTH_BITS-1:0] length;
  } event_t;

  // Length code k lasts 2^k tempo units; out-of-range codes clamp to the longest note.
  function automatic logic [UNIT_BITS-1:0] dur_units(input logic [LENGTH_BITS-1:0] code);
    logic [LENGTH_BITS-1:0] k;
    k = (code > LENGTH_BITS'(6)) ? LENGTH_BITS'(6) : code;
    return UNIT_BITS'(1) << k;
  endfunction
endpackage

// File: rtl/note_scheduler_fifo.sv
// Event FIFO for the note scheduler: power-of-two depth, registered occupancy, sync clear.
module note_fifo
  import note_scheduler_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    push,
  input  logic [EVENT_BITS-1:0]   din,
  input  logic                    pop,
  output logic [EVENT_BITS-1:0]   dout,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [EVENT_BITS-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic                  do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/note_scheduler.sv
// Plays queued note events for 2^length tempo units each, with an optional silent gap,
// supporting pause (play_en=0) and flush.
module note_scheduler
  import note_scheduler_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int GAP_UNITS = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tick_en,
  input  logic                    ev_valid,
  input  logic [NOTE_BITS-1:0]    ev_note,
  input  logic [OCTAVE_BITS-1:0]  ev_octave,
  input  logic [LENGTH_BITS-1:0]  ev_length,
  output logic                    ev_ready,
  input  logic                    play_en,
  input  logic                    flush,
  output logic                    tone_valid,
  output logic [NOTE_BITS-1:0]    tone_note,
  output logic [OCTAVE_BITS-1:0]  tone_octave,
  output logic                    busy,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow
);
  state_t               state, state_nxt;
  logic [UNIT_BITS-1:0] remaining, remaining_nxt;
  logic [UNIT_BITS-1:0] gap_cnt, gap_nxt;
  event_t               head, ev_in;
  logic                 full, empty, pop, push, unit;

  assign ev_in      = {ev_note, ev_octave, ev_length};
  assign ev_ready   = !full || pop;
  assign push       = ev_valid && ev_ready && !flush;
  assign unit       = tick_en && play_en;
  assign busy       = (state != S_IDLE) || !empty;
  assign tone_valid = (state == S_PLAY) && play_en;

  note_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .push  (push),
    .din   (ev_in),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    gap_nxt       = gap_cnt;
    pop           = 1'b0;
    case (state)
      S_IDLE: begin
        if (play_en && !empty) begin
          pop           = 1'b1;
          remaining_nxt = dur_units(head.length);
          state_nxt     = S_PLAY;
        end
      end
      S_PLAY: begin
        if (unit) begin
          if (remaining == UNIT_BITS'(1)) begin
            if (GAP_UNITS > 0) begin
              gap_nxt   = UNIT_BITS'(GAP_UNITS);
              state_nxt = S_GAP;
            end else if (!empty) begin
              // Legato: chain straight into the next note without leaving PLAY.
              pop           = 1'b1;
              remaining_nxt = dur_units(head.length);
            end else begin
              state_nxt = S_IDLE;
            end
          end else begin
            remaining_nxt = remaining - 1'b1;
          end
        end
      end
      S_GAP: begin
        if (unit) begin
          if (gap_cnt == UNIT_BITS'(1)) begin
            if (!empty) begin
              pop           = 1'b1;
              remaining_nxt = dur_units(head.length);
              state_nxt     = S_PLAY;
            end else begin
              state_nxt = S_IDLE;
            end
          end else begin
            gap_nxt = gap_cnt - 1'b1;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Flush aborts playback but keeps the last tone registers; only rst clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      remaining   <= '0;
      gap_cnt     <= '0;
      tone_note   <= '0;
      tone_octave <= '0;
      overflow    <= 1'b0;
    end else if (flush) begin
      state    <= S_IDLE;
      overflow <= 1'b0;
    end else begin
      state     <= state_nxt;
      remaining <= remaining_nxt;
      gap_cnt   <= gap_nxt;
      if (pop) begin
        tone_note   <= head.note;
        tone_octave <= head.octave;
      end
      if (ev_valid && !ev_ready) overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_note_scheduler.sv
// Directed scenarios plus random traffic, checked against a unit-counting queue model.
module tb_note_scheduler;
  import note_scheduler_pkg::*;

  localparam int DEPTH = 8;
  localparam int G     = 1;

  logic clk = 1'b0;
  logic rst, tick_en, ev_valid, play_en, flush;
  logic [NOTE_BITS-1:0]   ev_note;
  logic [OCTAVE_BITS-1:0] ev_octave;
  logic [LENGTH_BITS-1:0] ev_length;

  logic ev_ready, tone_valid, busy, overflow;
  logic [NOTE_BITS-1:0]   tone_note;
  logic [OCTAVE_BITS-1:0] tone_octave;
  logic [$clog2(DEPTH):0] count;

  logic ev_ready0, tv0, busy0, overflow0;
  logic [NOTE_BITS-1:0]   note0;
  logic [OCTAVE_BITS-1:0] oct0;
  logic [$clog2(DEPTH):0] count0;

  always #5 clk = ~clk;

  note_scheduler #(.DEPTH(DEPTH), .GAP_UNITS(G)) dut (
    .clk(clk), .rst(rst), .tick_en(tick_en), .ev_valid(ev_valid),
    .ev_note(ev_note), .ev_octave(ev_octave), .ev_length(ev_length),
    .ev_ready(ev_ready), .play_en(play_en), .flush(flush),
    .tone_valid(tone_valid), .tone_note(tone_note), .tone_octave(tone_octave),
    .busy(busy), .count(count), .overflow(overflow)
  );

  note_scheduler #(.DEPTH(DEPTH), .GAP_UNITS(0)) dut0 (
    .clk(clk), .rst(rst), .tick_en(tick_en), .ev_valid(ev_valid),
    .ev_note(ev_note), .ev_octave(ev_octave), .ev_length(ev_length),
    .ev_ready(ev_ready0), .play_en(play_en), .flush(flush),
    .tone_valid(tv0), .tone_note(note0), .tone_octave(oct0),
    .busy(busy0), .count(count0), .overflow(overflow0)
  );

  typedef struct {
    int note;
    int octave;
    int length;
  } mev_t;

  mev_t mq[$];
  int   m_units, m_gap, m_note, m_oct;
  bit   m_ovf;
  int   n_cmp, n_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_ev(input int n, input int o, input int l);
    ev_note   = NOTE_BITS'(n);
    ev_octave = OCTAVE_BITS'(o);
    ev_length = LENGTH_BITS'(l);
  endtask

  // Would the scheduler take the head event this cycle, given model state and inputs?
  function automatic bit model_pop();
    bit u;
    u = tick_en && play_en;
    if (m_units == 0 && m_gap == 0) return play_en && (mq.size() > 0);
    if (m_units > 0) return u && (m_units == 1) && (G == 0) && (mq.size() > 0);
    return u && (m_gap == 1) && (mq.size() > 0);
  endfunction

  task automatic step();
    bit   p, acc;
    mev_t e;
    #1;
    p = model_pop();
    chk("tone_valid",  tone_valid,  (m_units > 0) && play_en);
    chk("tone_note",   tone_note,   m_note);
    chk("tone_octave", tone_octave, m_oct);
    chk("busy",        busy,        (m_units > 0) || (m_gap > 0) || (mq.size() > 0));
    chk("count",       count,       mq.size());
    chk("ev_ready",    ev_ready,    (mq.size() < DEPTH) || p);
    chk("overflow",    overflow,    m_ovf);
    if (rst) begin
      mq.delete(); m_units = 0; m_gap = 0; m_note = 0; m_oct = 0; m_ovf = 0;
    end else if (flush) begin
      mq.delete(); m_units = 0; m_gap = 0; m_ovf = 0;
    end else begin
      acc = ev_valid && ((mq.size() < DEPTH) || p);
      if (ev_valid && !acc) m_ovf = 1;
      if (tick_en && play_en) begin
        if (m_units > 0) begin
          m_units--;
          if (m_units == 0) m_gap = G;
        end else if (m_gap > 0) begin
          m_gap--;
        end
      end
      if (p) begin
        e = mq.pop_front();
        m_note = e.note; m_oct = e.octave; m_units = 1 << e.length; m_gap = 0;
      end
      if (acc) begin
        e.note = int'(ev_note); e.octave = int'(ev_octave); e.length = int'(ev_length);
        mq.push_back(e);
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int hits, ghost, units, ph;
    n_cmp = 0; n_err = 0;
    m_units = 0; m_gap = 0; m_note = 0; m_oct = 0; m_ovf = 0;
    rst = 1; tick_en = 0; ev_valid = 0; play_en = 0; flush = 0;
    set_ev(0, 0, 0);
    @(posedge clk); #1;
    step();
    rst = 0;
    chk("rst_tone_valid", tone_valid, 1'b0);
    chk("rst_count", count, 0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_ev_ready", ev_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_note", tone_note, 0);

    // Duration with gap
    play_en = 1; tick_en = 1;
    set_ev(2, 4, 3); ev_valid = 1; step(); ev_valid = 0;
    chk("t1_latency", tone_valid, 1'b0);
    step();
    for (int i = 0; i < 8; i++) begin
      chk("t1_valid", tone_valid, 1'b1);
      chk("t1_note", tone_note, 2);
      chk("t1_oct", tone_octave, 4);
      step();
    end
    chk("t1_gap", tone_valid, 1'b0);
    chk("t1_gap_busy", busy, 1'b1);
    step();
    chk("t1_idle_busy", busy, 1'b0);

    // Legato back-to-back on the gapless instance
    set_ev(0, 1, 0); ev_valid = 1; step();
    set_ev(5, 2, 1); step(); ev_valid = 0;
    chk("t2_v0", tv0, 1'b1); chk("t2_n0", note0, 0); step();
    chk("t2_v1", tv0, 1'b1); chk("t2_n1", note0, 5); step();
    chk("t2_v2", tv0, 1'b1); chk("t2_n2", note0, 5); step();
    chk("t2_end", tv0, 1'b0);
    for (int i = 0; i < 4; i++) step();

    // Full FIFO while paused
    play_en = 0; tick_en = 0;
    for (int i = 0; i < 9; i++) begin
      set_ev(i % 7, i / 7, 0); ev_valid = 1; step();
    end
    ev_valid = 0;
    chk("t3_count", count, 8);
    chk("t3_ready", ev_ready, 1'b0);
    chk("t3_ovf", overflow, 1'b1);
    play_en = 1; tick_en = 1; hits = 0; ghost = 0;
    for (int i = 0; i < 24; i++) begin
      #1;
      if (tone_valid) begin
        hits++;
        if (tone_note == 1 && tone_octave == 1) ghost++;
      end
      step();
    end
    chk("t3_played", hits, 8);
    chk("t3_ninth", ghost, 0);

    // Push and pop in the same cycle at full
    play_en = 0; tick_en = 0; flush = 1; step(); flush = 0;
    for (int i = 0; i < 8; i++) begin
      set_ev(i % 7, 2, 0); ev_valid = 1; step();
    end
    chk("t4_full", count, 8);
    set_ev(6, 7, 0); play_en = 1;
    #1;
    chk("t4_ready", ev_ready, 1'b1);
    step(); ev_valid = 0;
    chk("t4_count", count, 8);
    chk("t4_ovf", overflow, 1'b0);
    tick_en = 1;
    for (int i = 0; i < 24; i++) step();
    chk("t4_drained", busy, 1'b0);

    // Pause and resume mid-note
    tick_en = 0; ph = 0; units = 0;
    set_ev(3, 2, 2); ev_valid = 1; step(); ev_valid = 0;
    for (int k = 0; k < 40 && units < 1; k++) begin
      tick_en = (ph % 4 == 3); #1;
      if (tone_valid && tick_en) units++;
      step(); ph++;
    end
    chk("t5_first", units, 1);
    play_en = 0;
    for (int i = 0; i < 20; i++) begin
      tick_en = (ph % 4 == 3); #1;
      chk("t5_pause", tone_valid, 1'b0);
      step(); ph++;
    end
    play_en = 1; units = 0;
    for (int i = 0; i < 40; i++) begin
      tick_en = (ph % 4 == 3); #1;
      if (tone_valid && tick_en) units++;
      step(); ph++;
    end
    chk("t5_resume", units, 3);
    tick_en = 0;

    // Flush mid-note, with a push in the flush cycle
    for (int i = 0; i < 4; i++) begin
      set_ev(i + 1, 3, 2); ev_valid = 1; step();
    end
    ev_valid = 0;
    chk("t6_queued", count, 3);
    chk("t6_playing", tone_valid, 1'b1);
    flush = 1; ev_valid = 1; set_ev(6, 6, 0); step(); flush = 0; ev_valid = 0;
    chk("t6_count", count, 0);
    chk("t6_valid", tone_valid, 1'b0);
    chk("t6_busy", busy, 1'b0);
    chk("t6_ovf", overflow, 1'b0);
    tick_en = 1;
    set_ev(4, 5, 1); ev_valid = 1; step(); ev_valid = 0;
    step();
    for (int i = 0; i < 2; i++) begin
      chk("t6_replay", tone_valid, 1'b1);
      chk("t6_note", tone_note, 4);
      step();
    end
    chk("t6_done", tone_valid, 1'b0);

    // Random traffic against the model
    for (int i = 0; i < 800; i++) begin
      rst      = ($urandom_range(0, 299) == 0);
      flush    = ($urandom_range(0, 99) == 0);
      play_en  = ($urandom_range(0, 99) < 85);
      tick_en  = ($urandom_range(0, 1) == 1);
      ev_valid = ($urandom_range(0, 99) < 35);
      set_ev($urandom_range(0, 6), $urandom_range(0, 7), $urandom_range(0, 3));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
